axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axil_pkg.sv | 16 +
 rtl/axi_lite_master.sv | 159 +++++++++++++++
 tb/tb_axi_lite_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI-Lite response codes and master FSM states
package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } axil_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI-Lite master with command/done interface
// Optional per-channel wait limit enabled by AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axil_pkg::*;
#(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                         done,
  output logic [AXIL_DATA_WIDTH-1:0]   done_rdata,
  output logic [1:0]                   done_resp,
  output logic                         done_timeout,
  output logic                         awvalid,
  output logic [AXIL_ADDR_WIDTH-1:0]   awaddr,
  input  logic                         awready,
  output logic                         wvalid,
  output logic [AXIL_DATA_WIDTH-1:0]   wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
  input  logic                         wready,
  input  logic                         bvalid,
  input  logic [1:0]                   bresp,
  output logic                         bready,
  output logic                         arvalid,
  output logic [AXIL_ADDR_WIDTH-1:0]   araddr,
  input  logic                         arready,
  input  logic                         rvalid,
  input  logic [AXIL_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                   rresp,
  output logic                         rready
);

  axil_state_e                  state, state_n;
  logic [AXIL_ADDR_WIDTH-1:0]   addr_q;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q;
  logic [AXIL_DATA_WIDTH/8-1:0] wstrb_q;
  logic [AXIL_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                   resp_q;
  logic                         aw_done_q, w_done_q;
  logic                         tmo_expired, timeout_hit;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag_q;

  // tmo_cnt holds cycles already spent, so the current cycle is number tmo_cnt+1
  assign tmo_expired  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign done_timeout = tmo_flag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt    <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_flag_q <= timeout_hit;
      if (state_n != state)
        tmo_cnt <= '0;
      else if (state != ST_IDLE && state != ST_DONE)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  // constant false; the comparison only keeps the parameter referenced
  assign tmo_expired  = (TIMEOUT_CYCLES < 0);
  assign done_timeout = 1'b0;
`endif

  assign awaddr     = addr_q;
  assign araddr     = addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign done_rdata = rdata_q;
  assign done_resp  = resp_q;

  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    cmd_ready   = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = cmd_write ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        // each channel counts as done if it finished earlier or handshakes now
        if ((aw_done_q || awready) && (w_done_q || wready)) state_n = ST_WR_RESP;
        else if (tmo_expired) begin state_n = ST_DONE; timeout_hit = 1'b1; end
      end
      ST_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_n = ST_DONE;
        else if (tmo_expired) begin state_n = ST_DONE; timeout_hit = 1'b1; end
      end
      ST_RD_REQ: begin
        arvalid = 1'b1;
        if (arready) state_n = ST_RD_RESP;
        else if (tmo_expired) begin state_n = ST_DONE; timeout_hit = 1'b1; end
      end
      ST_RD_RESP: begin
        rready = 1'b1;
        if (rvalid) state_n = ST_DONE;
        else if (tmo_expired) begin state_n = ST_DONE; timeout_hit = 1'b1; end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= AXIL_RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (cmd_valid && cmd_ready) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        wstrb_q   <= cmd_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (awvalid && awready) aw_done_q <= 1'b1;
      if (wvalid && wready)   w_done_q  <= 1'b1;
      if (bvalid && bready)   resp_q    <= bresp;
      if (rvalid && rready) begin
        rdata_q <= rdata;
        resp_q  <= rresp;
      end
      if (timeout_hit) resp_q <= AXIL_RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - directed and randomized checks of axi_lite_master against a memory slave model
module tb_axi_lite_master;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        done, done_timeout;
  logic [31:0] done_rdata;
  logic [1:0]  done_resp;
  logic        awvalid, awready = 1'b0;
  logic [3:0]  awaddr;
  logic        wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = 2'b00;
  logic        arvalid, arready = 1'b0;
  logic [3:0]  araddr;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;

  axi_lite_master #(.AXIL_DATA_WIDTH(32), .AXIL_ADDR_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .done(done), .done_rdata(done_rdata), .done_resp(done_resp), .done_timeout(done_timeout),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  always #5 clk = ~clk;

  // slave configuration, memory and handshake bookkeeping
  int          cfg_aw_lat = 0, cfg_w_lat = 0, cfg_b_lat = 0, cfg_ar_lat = 0, cfg_r_lat = 0;
  logic [1:0]  cfg_bresp = AXIL_RESP_OKAY, cfg_rresp = AXIL_RESP_OKAY;
  bit          cfg_rforce = 0;
  logic [31:0] cfg_rdata = '0;
  logic [31:0] slv_mem [16];
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit          aw_have = 0, w_have = 0, ar_have = 0;
  logic [3:0]  s_awaddr = '0, s_araddr = '0, s_wstrb = '0;
  logic [31:0] s_wdata = '0;
  logic        p_bready = 1'b0, p_rready = 1'b0;

  // Slave acts on falling edges; *ready/*valid it drove are seen by the DUT at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_have = 0; w_have = 0; ar_have = 0; p_bready = 0; p_rready = 0;
    end else begin
      if (awready) begin awready = 0; aw_have = 1; aw_cnt = 0; end
      if (wready)  begin wready = 0;  w_have = 1;  w_cnt = 0;  end
      if (arready) begin arready = 0; ar_have = 1; ar_cnt = 0; end
      if (bvalid && p_bready) bvalid = 0;
      if (rvalid && p_rready) rvalid = 0;
      if (awvalid && !aw_have) begin
        if (aw_cnt >= cfg_aw_lat) begin awready = 1; s_awaddr = awaddr; end else aw_cnt++;
      end else aw_cnt = 0;
      if (wvalid && !w_have) begin
        if (w_cnt >= cfg_w_lat) begin wready = 1; s_wdata = wdata; s_wstrb = wstrb; end else w_cnt++;
      end else w_cnt = 0;
      if (arvalid && !ar_have) begin
        if (ar_cnt >= cfg_ar_lat) begin arready = 1; s_araddr = araddr; end else ar_cnt++;
      end else ar_cnt = 0;
      if (aw_have && w_have && !bvalid) begin
        if (b_cnt >= cfg_b_lat) begin
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) slv_mem[s_awaddr][8*i +: 8] = s_wdata[8*i +: 8];
          bvalid = 1; bresp = cfg_bresp; aw_have = 0; w_have = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (ar_have && !rvalid) begin
        if (r_cnt >= cfg_r_lat) begin
          rdata = cfg_rforce ? cfg_rdata : slv_mem[s_araddr];
          rresp = cfg_rresp; rvalid = 1; ar_have = 0; r_cnt = 0;
        end else r_cnt++;
      end
      p_bready = bready;
      p_rready = rready;
    end
  end

  int          errors = 0, checks = 0;
  logic [31:0] model_mem [16];
  logic [31:0] exp_last_rdata = '0;
  logic [31:0] exp_rd;
  logic [1:0]  exp_resp;
  int          r_lat, r_ndone, r_aw_hi, r_w_hi, exp_lat, la, lw, lb;
  bit          r_bad_payload, r_tmo;
  logic [31:0] r_rdata, r_rdata_hold;
  logic [1:0]  r_resp, r_resp_hold;
  bit          t_wr;
  logic [3:0]  t_a, t_s;
  logic [31:0] t_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Issues one command; latency counts falling edges after the accepting rising edge until done is seen.
  task automatic run_txn(input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int g = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    r_lat = -1; r_ndone = 0; r_aw_hi = 0; r_w_hi = 0; r_bad_payload = 0; r_tmo = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) cmd_valid = 0;
      if (awvalid) begin r_aw_hi++; if (awaddr !== a) r_bad_payload = 1; end
      if (wvalid)  begin r_w_hi++;  if (wdata !== d || wstrb !== s) r_bad_payload = 1; end
      if (arvalid && araddr !== a) r_bad_payload = 1;
      if (done) begin
        r_ndone++;
        if (r_lat < 0) begin r_lat = n; r_rdata = done_rdata; r_resp = done_resp; r_tmo = done_timeout; end
      end
      if (r_lat >= 0 && n >= r_lat + 2) begin
        r_rdata_hold = done_rdata; r_resp_hold = done_resp;
        break;
      end
    end
  endtask

  task automatic check_txn(input string tag, input int lat, input logic [31:0] rd, input logic [1:0] resp);
    chk({tag, "_lat"}, 64'(r_lat), 64'(lat));
    chk({tag, "_ndone"}, 64'(r_ndone), 64'd1);
    chk({tag, "_rdata"}, 64'(r_rdata), 64'(rd));
    chk({tag, "_resp"}, 64'(r_resp), 64'(resp));
    chk({tag, "_hold"}, {30'd0, r_resp_hold, r_rdata_hold}, {30'd0, resp, rd});
    chk({tag, "_payload"}, 64'(r_bad_payload), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin slv_mem[i] = '0; model_mem[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, done, done_timeout}), 64'd0);
    chk("rst_rdata", 64'(done_rdata), 64'd0);
    chk("rst_resp", 64'(done_resp), 64'd0);
    reset = 0;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // zero-wait write then read back
    run_txn(1, 4'h3, 32'hDEADBEEF, 4'hF);
    model_mem[3] = merge(model_mem[3], 32'hDEADBEEF, 4'hF);
    check_txn("wr0", 3, exp_last_rdata, AXIL_RESP_OKAY);
    chk("mem3", 64'(slv_mem[3]), 64'hDEADBEEF);
    run_txn(0, 4'h3, 32'h0, 4'h0);
    exp_last_rdata = model_mem[3];
    check_txn("rd0", 3, 32'hDEADBEEF, AXIL_RESP_OKAY);

    // wready four cycles after awready
    cfg_w_lat = 4;
    run_txn(1, 4'h5, 32'hA5A5_0F0F, 4'hF);
    model_mem[5] = merge(model_mem[5], 32'hA5A5_0F0F, 4'hF);
    check_txn("wslow", 7, exp_last_rdata, AXIL_RESP_OKAY);
    chk("wslow_aw_hi", 64'(r_aw_hi), 64'd1);
    chk("wslow_w_hi", 64'(r_w_hi), 64'd5);
    chk("mem5", 64'(slv_mem[5]), 64'hA5A5_0F0F);
    cfg_w_lat = 0;

    // error read response with forced data
    cfg_rforce = 1; cfg_rdata = 32'h12345678; cfg_rresp = AXIL_RESP_SLVERR; cfg_r_lat = 2;
    run_txn(0, 4'h7, 32'h0, 4'h0);
    exp_last_rdata = 32'h12345678;
    check_txn("rderr", 5, 32'h12345678, AXIL_RESP_SLVERR);
    cfg_rforce = 0; cfg_rresp = AXIL_RESP_OKAY; cfg_r_lat = 0;

    // randomized mix with random waits and responses
    for (int k = 0; k < 24; k++) begin
      t_wr = 1'($urandom_range(0, 1));
      t_a = 4'($urandom_range(0, 15));
      t_d = $urandom;
      t_s = 4'($urandom_range(1, 15));
      la = $urandom_range(0, 3); lw = $urandom_range(0, 3); lb = $urandom_range(0, 3);
      exp_resp = $urandom_range(0, 1) ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
      if (t_wr) begin
        cfg_aw_lat = la; cfg_w_lat = lw; cfg_b_lat = lb; cfg_bresp = exp_resp;
        exp_lat = 3 + ((la > lw) ? la : lw) + lb;
        model_mem[t_a] = merge(model_mem[t_a], t_d, t_s);
        exp_rd = exp_last_rdata;
      end else begin
        cfg_ar_lat = la; cfg_r_lat = lb; cfg_rresp = exp_resp;
        exp_lat = 3 + la + lb;
        exp_rd = model_mem[t_a];
        exp_last_rdata = exp_rd;
      end
      run_txn(t_wr, t_a, t_d, t_s);
      check_txn(t_wr ? "rnd_wr" : "rnd_rd", exp_lat, exp_rd, exp_resp);
      chk("rnd_tmo", 64'(r_tmo), 64'd0);
    end
    cfg_aw_lat = 0; cfg_w_lat = 0; cfg_b_lat = 0; cfg_ar_lat = 0; cfg_r_lat = 0;
    cfg_bresp = AXIL_RESP_OKAY; cfg_rresp = AXIL_RESP_OKAY;

    // reset while waiting for the write response
    cfg_b_lat = 5;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h9; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    for (int g = 0; g < 20 && !bready; g++) @(negedge clk);
    chk("abort_in_wr_resp", 64'(bready), 64'd1);
    reset = 1;
    @(negedge clk);
    chk("abort_outs", 64'({awvalid, wvalid, bready, arvalid, rready, done, done_timeout}), 64'd0);
    chk("abort_rdata", 64'(done_rdata), 64'd0);
    chk("abort_resp", 64'(done_resp), 64'd0);
    reset = 0;
    exp_last_rdata = '0;
    cfg_b_lat = 0;
    @(negedge clk);
    chk("abort_ready", 64'({cmd_ready, done}), 64'b10);
    run_txn(1, 4'h9, 32'hCAFE_F00D, 4'hF);
    model_mem[9] = merge(model_mem[9], 32'hCAFE_F00D, 4'hF);
    check_txn("post_rst_wr", 3, 32'h0, AXIL_RESP_OKAY);
    run_txn(0, 4'h9, 32'h0, 4'h0);
    exp_last_rdata = model_mem[9];
    check_txn("post_rst_rd", 3, model_mem[9], AXIL_RESP_OKAY);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // arready never arrives: abort after 8 cycles in RD_REQ
    cfg_ar_lat = 1000;
    run_txn(0, 4'h2, 32'h0, 4'h0);
    check_txn("tmo", 9, exp_last_rdata, AXIL_RESP_SLVERR);
    chk("tmo_flag", 64'(r_tmo), 64'd1);
    chk("tmo_arvalid", 64'(arvalid), 64'd0);
    cfg_ar_lat = 0;
    run_txn(0, 4'h5, 32'h0, 4'h0);
    exp_last_rdata = model_mem[5];
    check_txn("tmo_recover", 3, model_mem[5], AXIL_RESP_OKAY);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
